// File: rtl/gray_fifo_ptr_ctrl_pkg.sv
// gray_fifo_ptr_ctrl_pkg: shared pointer sizing and Gray full-compare mask helpers
package gray_fifo_ptr_ctrl_pkg;
  function automatic int ptr_width(input int bw_addr);
    return bw_addr + 1;
  endfunction
  function automatic int fifo_depth(input int bw_addr);
    return 1 << bw_addr;
  endfunction
  // Full in Gray code: write pointer equals read pointer with its two MSBs inverted
  function automatic logic [31:0] gray_full_mask(input int pw);
    return 32'd3 << (pw - 2);
  endfunction
endpackage

// File: rtl/bin_to_gray.sv
// bin_to_gray: combinational binary to reflected Gray code converter
module bin_to_gray #(
  parameter int BW_DATA = 5
) (
  input  logic [BW_DATA-1:0] i_bin,
  output logic [BW_DATA-1:0] o_gray
);
  assign o_gray = i_bin ^ (i_bin >> 1);
endmodule

// File: rtl/gray_fifo_ptr_ctrl.sv
// gray_fifo_ptr_ctrl: single-clock FIFO pointer/flag controller with Gray-coded pointers
module gray_fifo_ptr_ctrl
  import gray_fifo_ptr_ctrl_pkg::*;
#(
  parameter int BW_ADDR = 4
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_clr,
  input  logic               i_wr_en,
  input  logic               i_rd_en,
  output logic               o_wr_ack,
  output logic               o_rd_ack,
  output logic [BW_ADDR-1:0] o_wr_addr,
  output logic [BW_ADDR-1:0] o_rd_addr,
  output logic [BW_ADDR:0]   o_wr_ptr_gray,
  output logic [BW_ADDR:0]   o_rd_ptr_gray,
  output logic               o_full,
  output logic               o_empty,
  output logic [BW_ADDR:0]   o_level,
  output logic               o_ovf,
  output logic               o_udf
);
  localparam int PW = ptr_width(BW_ADDR);
  localparam logic [PW-1:0] FULL_MASK = PW'(gray_full_mask(PW));
  logic [PW-1:0] wr_bin, rd_bin, wr_bin_nxt, rd_bin_nxt, wr_gray_nxt, rd_gray_nxt;
  assign o_wr_ack = i_wr_en & ~o_full & ~i_clr;
  assign o_rd_ack = i_rd_en & ~o_empty & ~i_clr;
  assign o_wr_addr = wr_bin[BW_ADDR-1:0];
  assign o_rd_addr = rd_bin[BW_ADDR-1:0];
  always_comb begin
    wr_bin_nxt = i_clr ? '0 : wr_bin + PW'(o_wr_ack);
    rd_bin_nxt = i_clr ? '0 : rd_bin + PW'(o_rd_ack);
  end
  bin_to_gray #(.BW_DATA(PW)) u_wr_b2g (.i_bin(wr_bin_nxt), .o_gray(wr_gray_nxt));
  bin_to_gray #(.BW_DATA(PW)) u_rd_b2g (.i_bin(rd_bin_nxt), .o_gray(rd_gray_nxt));
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_bin        <= '0;
      rd_bin        <= '0;
      o_wr_ptr_gray <= '0;
      o_rd_ptr_gray <= '0;
      o_level       <= '0;
      o_empty       <= 1'b1;
      o_full        <= 1'b0;
      o_ovf         <= 1'b0;
      o_udf         <= 1'b0;
    end else begin
      wr_bin        <= wr_bin_nxt;
      rd_bin        <= rd_bin_nxt;
      o_wr_ptr_gray <= wr_gray_nxt;
      o_rd_ptr_gray <= rd_gray_nxt;
      o_level       <= wr_bin_nxt - rd_bin_nxt;
      o_empty       <= wr_gray_nxt == rd_gray_nxt;
      o_full        <= wr_gray_nxt == (rd_gray_nxt ^ FULL_MASK);
      o_ovf         <= ~i_clr & (o_ovf | (i_wr_en & o_full));
      o_udf         <= ~i_clr & (o_udf | (i_rd_en & o_empty));
    end
  end
endmodule

// File: doc/gray_fifo_ptr_ctrl.md
Name: gray_fifo_ptr_ctrl

Overview:
Pointer/flag controller for a single-clock FIFO whose read and write pointers are kept in Gray code, ready for later CDC reuse. It sequences push/pop requests and generates binary RAM addresses, Gray-coded pointers, full/empty flags, fill level and sticky error flags. It instantiates the team's bin_to_gray converter for both pointers. It sits between requesters and a dual-port RAM; it holds no data storage.

Parameters:
BW_ADDR, 4, RAM address width; FIFO depth = 2**BW_ADDR; pointers are BW_ADDR+1 bits.

Ports:
i_clk  input  1  clock, rising edge
i_rstn  input  1  asynchronous active-low reset
i_clr  input  1  synchronous clear of pointers and error flags
i_wr_en  input  1  push request
i_rd_en  input  1  pop request
o_wr_ack  output  1  push accepted this cycle (combinational)
o_rd_ack  output  1  pop accepted this cycle (combinational)
o_wr_addr  output  BW_ADDR  RAM write address (binary write pointer LSBs)
o_rd_addr  output  BW_ADDR  RAM read address (binary read pointer LSBs)
o_wr_ptr_gray  output  BW_ADDR+1  Gray-coded write pointer, registered
o_rd_ptr_gray  output  BW_ADDR+1  Gray-coded read pointer, registered
o_full  output  1  FIFO full, registered
o_empty  output  1  FIFO empty, registered
o_level  output  BW_ADDR+1  entry count, 0..2**BW_ADDR, registered
o_ovf  output  1  sticky: push attempted while full
o_udf  output  1  sticky: pop attempted while empty

Behaviour:
- Reset (i_rstn=0, asynchronous): binary and Gray pointers = 0, o_level = 0, o_empty = 1, o_full = 0, o_ovf = o_udf = 0.
- Internal state: binary pointers wr_bin and rd_bin, each BW_ADDR+1 bits, plus registered Gray copies.
- Handshakes: o_wr_ack = i_wr_en & ~o_full & ~i_clr; o_rd_ack = i_rd_en & ~o_empty & ~i_clr.
- On o_wr_ack, wr_bin increments by 1 at the next edge. On o_rd_ack, rd_bin increments by 1 at the next edge. Both wrap modulo 2**(BW_ADDR+1).
- Gray pointers register bin_to_gray(next binary pointer), so o_*_ptr_gray always matches the binary pointer in the same cycle. Latency from accepted request to updated address, flags and level is 1 cycle.
- Flags are computed from the next Gray pointers and registered:
  - empty when next_wr_gray == next_rd_gray;
  - full when next_wr_gray == {~next_rd_gray[MSB:MSB-1], next_rd_gray[MSB-2:0]}.
- o_level = wr_bin - rd_bin modulo 2**(BW_ADDR+1), registered on the same edge as the pointers.
- Simultaneous push and pop:
  - not full and not empty: both accepted; level and flags unchanged; both pointers advance.
  - when full: only the pop is accepted; the push is rejected and sets o_ovf.
  - when empty: only the push is accepted; the pop is rejected and sets o_udf.
- o_ovf sets on i_wr_en & o_full. o_udf sets on i_rd_en & o_empty. Both hold until i_clr or reset.
- i_clr has priority over push/pop. At the next edge it returns pointers, level, flags and error flags to reset values. No acks are issued in the clr cycle.
- Reset asserted mid-operation: all state returns to reset values immediately; no partial update.
- Wrap: after 2**(BW_ADDR+1) pushes and pops, pointers return to 0 and Gray sequences remain single-bit-change per increment.

Decomposition:
- Shared package/header holds the pointer width (BW_ADDR+1), depth, and Gray full-compare mask helper.
- Sub-module: bin_to_gray (existing, BW_DATA = BW_ADDR+1), instantiated twice, once per pointer. No other sub-modules.

Test Plan (BW_ADDR=4, depth 16):
1. Reset, then idle 3 cycles -> o_empty=1, o_full=0, o_level=0, both Gray pointers 0, no acks.
2. 16 consecutive pushes -> o_wr_ack high all 16 cycles, o_level 1..16, o_full=1 after 16th edge, o_wr_ptr_gray = 5'b11000. A 17th push -> o_wr_ack=0, o_ovf=1, pointer unchanged.
3. From full, simultaneous push+pop -> only the pop is acked, o_level=15, o_full=0. Then 15 pops -> o_empty=1, o_rd_addr=0, o_rd_ptr_gray = 5'b11000. An extra pop -> o_udf=1.
4. Fill to 8, then 40 cycles of simultaneous push+pop -> o_level stays 8 and pointers wrap past 31 to 0. A checker compares each Gray pointer to bin^(bin>>1) and confirms exactly one bit changes per increment.
5. With level 5 and o_ovf=1, pulse i_clr together with i_wr_en -> no ack; next cycle all outputs equal reset values.
6. Assert i_rstn=0 mid-push at level 9, between clock edges -> outputs go to reset values before the next edge; after release the first push gives o_wr_addr=0 then 1.
